// File: rtl/tama_pkg.sv
// Shared definitions for the tamagotchi button conditioning path.
// Optional long-press support is selected with the TAMA_BTN_LONG_EN macro.
package tama_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEB_PRESS,
      ST_HELD,
      ST_LONG_HELD,
      ST_DEB_REL
   } btn_state_e;

   localparam int unsigned BTN_SALUD     = 0;
   localparam int unsigned BTN_ENERGIA   = 1;
   localparam int unsigned BTN_HAMBRE    = 2;
   localparam int unsigned BTN_DIVERSION = 3;
   localparam int unsigned BTN_RESET     = 4;
   localparam int unsigned BTN_TEST      = 5;

   // Counter must hold the largest tick count it is compared against.
   function automatic int unsigned cnt_width(input bit long_en,
                                             input int unsigned debounce_ms,
                                             input int unsigned long_ms);
      int unsigned top_val;
      top_val = debounce_ms;
      if (long_en && (long_ms > debounce_ms))
         top_val = long_ms;
      return (top_val < 1) ? 1 : $clog2(top_val + 1);
   endfunction

endpackage

// File: rtl/tama_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce/long-press FSM, pulse outputs.
// Long-press detection is compiled in only when TAMA_BTN_LONG_EN is defined.
module tama_btn_channel
   import tama_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 5000
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);

`ifdef TAMA_BTN_LONG_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   localparam int unsigned CW = cnt_width(LONG_EN, DEBOUNCE_MS, LONG_MS);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_MS - 1);
`ifdef TAMA_BTN_LONG_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
`endif

   logic          sync1, sync2, s;
   btn_state_e    state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic          from_long, from_long_n;
   logic          level_n, press_n, release_n, long_n;

   assign s       = ~sync2;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1       <= 1'b1;
         sync2       <= 1'b1;
         state       <= ST_IDLE;
         cnt         <= '0;
         from_long   <= 1'b0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
      end else begin
         sync1       <= btn_raw;
         sync2       <= sync1;
         state       <= state_n;
         cnt         <= cnt_n;
         from_long   <= from_long_n;
         btn_level   <= level_n;
         btn_press   <= press_n;
         btn_release <= release_n;
         btn_long    <= long_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      from_long_n = from_long;
      case (state)
         ST_IDLE: begin
            if (s) begin
               state_n = ST_DEB_PRESS;
               cnt_n   = '0;
            end
         end
         ST_DEB_PRESS: begin
            if (!s) begin
               state_n = ST_IDLE;
            end else if (tick) begin
               if (cnt == DEB_LAST) begin
                  state_n = ST_HELD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         ST_HELD: begin
            if (!s) begin
               state_n     = ST_DEB_REL;
               cnt_n       = '0;
               from_long_n = 1'b0;
            end
`ifdef TAMA_BTN_LONG_EN
            else if (tick) begin
               if (cnt == LONG_LAST)
                  state_n = ST_LONG_HELD;
               else
                  cnt_n = cnt_inc;
            end
`endif
         end
         ST_LONG_HELD: begin
            if (!s) begin
               state_n     = ST_DEB_REL;
               cnt_n       = '0;
               from_long_n = 1'b1;
            end
         end
         ST_DEB_REL: begin
            // A release that does not survive debounce restarts the hold timer.
            if (s) begin
               state_n = from_long ? ST_LONG_HELD : ST_HELD;
               cnt_n   = '0;
            end else if (tick) begin
               if (cnt == DEB_LAST) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      press_n   = (state == ST_DEB_PRESS) && (state_n == ST_HELD);
      release_n = (state == ST_DEB_REL) && (state_n == ST_IDLE);
      level_n   = (state_n == ST_HELD) || (state_n == ST_LONG_HELD) ||
                  (state_n == ST_DEB_REL);
`ifdef TAMA_BTN_LONG_EN
      long_n    = (state == ST_HELD) && (state_n == ST_LONG_HELD);
`else
      long_n    = 1'b0;
`endif
   end

endmodule

// File: rtl/tamagotchi_btn_cond.sv
// Pushbutton conditioning: shared 1 ms tick prescaler feeding N_BTN channels.
// Define TAMA_BTN_LONG_EN to enable the long-press pulse on btn_long.
module tamagotchi_btn_cond
   import tama_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned N_BTN       = 6,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 5000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   localparam int unsigned TICK_DIV = CLK_HZ / 1000;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;
   logic          tick;

   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (!reset)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      tama_btn_channel #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .LONG_MS     (LONG_MS)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .tick        (tick),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_long    (btn_long[i])
      );
   end

endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Directed bench for tamagotchi_btn_cond: 10 cycles/tick, 3-tick debounce, 20-tick long press.
// Long-press expectations follow whether TAMA_BTN_LONG_EN is defined.
module tb_tamagotchi_btn_cond;

   localparam int unsigned NB = 6;
`ifdef TAMA_BTN_LONG_EN
   localparam int EXP_LONG = 1;
`else
   localparam int EXP_LONG = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NB-1:0] btn_raw = '1;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int press_cnt[NB] = '{default: 0};
   int rel_cnt[NB]   = '{default: 0};
   int long_cnt[NB]  = '{default: 0};
   int press_cyc[NB] = '{default: -100000};
   int rel_cyc[NB]   = '{default: -100000};
   int long_cyc[NB]  = '{default: -100000};

   int t0, p, p3, r, r3, l, lat;

   tamagotchi_btn_cond #(
      .CLK_HZ      (10_000),
      .N_BTN       (NB),
      .DEBOUNCE_MS (3),
      .LONG_MS     (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NB; i++) begin
         if (btn_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
         if (btn_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
         if (btn_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      end
   end

   task automatic chk(input string tag, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int in_win(input int v);
      return (v >= 24 && v <= 33) ? 1 : 0;
   endfunction

   initial begin
      // Reset state
      btn_raw = '1;
      reset   = 1'b0;
      wait_n(3);
      chk("rst_level",   int'(btn_level),   0);
      chk("rst_press",   int'(btn_press),   0);
      chk("rst_release", int'(btn_release), 0);
      chk("rst_long",    int'(btn_long),    0);
      reset = 1'b1;
      wait_n(5);

      // Clean press on channel 0 held 10 ms
      p = press_cnt[0]; l = long_cnt[0]; t0 = cyc;
      btn_raw[0] = 1'b0;
      wait_n(100);
      chk("t1_press_cnt", press_cnt[0] - p, 1);
      chk("t1_press_lat_ok", in_win(press_cyc[0] - t0), 1);
      chk("t1_level", int'(btn_level[0]), 1);
      chk("t1_no_long", long_cnt[0] - l, 0);
      r = rel_cnt[0]; t0 = cyc;
      btn_raw[0] = 1'b1;
      wait_n(50);
      chk("t1_rel_cnt", rel_cnt[0] - r, 1);
      chk("t1_rel_lat_ok", in_win(rel_cyc[0] - t0), 1);
      chk("t1_level_off", int'(btn_level[0]), 0);
      chk("t1_single_press", press_cnt[0] - p, 1);

      // Bouncing channel 2, then stable
      p = press_cnt[2];
      for (int i = 0; i < 20; i++) begin
         btn_raw[2] = ~btn_raw[2];
         wait_n(5);
      end
      chk("t2_no_press_bounce", press_cnt[2] - p, 0);
      chk("t2_level_bounce", int'(btn_level[2]), 0);
      t0 = cyc;
      btn_raw[2] = 1'b0;
      wait_n(50);
      chk("t2_press_cnt", press_cnt[2] - p, 1);
      chk("t2_press_lat_ok", in_win(press_cyc[2] - t0), 1);
      btn_raw[2] = 1'b1;
      wait_n(50);

      // Long press on channel 4
      p = press_cnt[4]; l = long_cnt[4]; r = rel_cnt[4];
      btn_raw[4] = 1'b0;
      wait_n(260);
      chk("t3_press_cnt", press_cnt[4] - p, 1);
      chk("t3_long_cnt", long_cnt[4] - l, EXP_LONG);
`ifdef TAMA_BTN_LONG_EN
      chk("t3_long_delay", long_cyc[4] - press_cyc[4], 200);
`endif
      wait_n(100);
      chk("t3_long_once", long_cnt[4] - l, EXP_LONG);
      chk("t3_level_held", int'(btn_level[4]), 1);
      btn_raw[4] = 1'b1;
      wait_n(50);
      chk("t3_rel_cnt", rel_cnt[4] - r, 1);
      chk("t3_no_long_on_rel", long_cnt[4] - l, EXP_LONG);

      // One-tick release glitch on channel 5 restarts the hold timer
      p = press_cnt[5]; l = long_cnt[5]; r = rel_cnt[5];
      btn_raw[5] = 1'b0;
      wait_n(40);
      chk("t4_press_cnt", press_cnt[5] - p, 1);
      while (cyc < press_cyc[5] + 50) @(negedge clk);
      btn_raw[5] = 1'b1;
      wait_n(10);
      btn_raw[5] = 1'b0;
      wait_n(250);
      chk("t4_no_release", rel_cnt[5] - r, 0);
      chk("t4_level_held", int'(btn_level[5]), 1);
      chk("t4_long_cnt", long_cnt[5] - l, EXP_LONG);
`ifdef TAMA_BTN_LONG_EN
      chk("t4_long_delay", long_cyc[5] - press_cyc[5], 260);
`endif
      btn_raw[5] = 1'b1;
      wait_n(50);
      chk("t4_rel_cnt", rel_cnt[5] - r, 1);

      // Channels 0 and 3 together
      p = press_cnt[0]; p3 = press_cnt[3];
      btn_raw = btn_raw & ~6'b001001;
      wait_n(50);
      chk("t5_press0", press_cnt[0] - p, 1);
      chk("t5_press3", press_cnt[3] - p3, 1);
      chk("t5_same_cycle", press_cyc[3], press_cyc[0]);
      r = rel_cnt[0]; r3 = rel_cnt[3];
      btn_raw = btn_raw | 6'b001001;
      wait_n(50);
      chk("t5_rel0", rel_cnt[0] - r, 1);
      chk("t5_rel3", rel_cnt[3] - r3, 1);
      chk("t5_rel_same_cycle", rel_cyc[3], rel_cyc[0]);

      // Reset while channel 1 is held
      p = press_cnt[1];
      btn_raw[1] = 1'b0;
      wait_n(50);
      chk("t6_press_cnt", press_cnt[1] - p, 1);
      r = rel_cnt[1];
      reset = 1'b0;
      wait_n(2);
      chk("t6_rst_level", int'(btn_level), 0);
      chk("t6_rst_press", int'(btn_press), 0);
      chk("t6_rst_release", int'(btn_release), 0);
      reset = 1'b1;
      p = press_cnt[1]; t0 = cyc;
      wait_n(50);
      chk("t6_repress_cnt", press_cnt[1] - p, 1);
      chk("t6_repress_lat_ok", in_win(press_cyc[1] - t0), 1);
      chk("t6_no_release", rel_cnt[1] - r, 0);
      chk("t6_level", int'(btn_level[1]), 1);
      btn_raw[1] = 1'b1;
      wait_n(50);
      chk("t6_rel_cnt", rel_cnt[1] - r, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
